// File: rtl/spike_pkg.sv
// Shared types and constants for the spike event packer: event word layout and drop counter limit.
package spike_pkg;

  localparam int SRC_W = 2;
  localparam int TS_W  = 14;
  localparam logic [SRC_W-1:0] SRC_MARKER = 2'b11;
  localparam logic [15:0] DROP_SAT = 16'hFFFF;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [TS_W-1:0]  ts;
  } event_t;

  // Saturating accumulate for the lost-event counter.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(b);
    return sum[16] ? DROP_SAT : sum[15:0];
  endfunction

endpackage

// File: rtl/spike_fifo_fwft.sv
// First-word-fall-through event FIFO, 2^DEPTH_LOG2 x 16; write lands one clock before it is readable.
// Writes while full and reads while empty are ignored; level/full/empty come straight from registers.
module spike_fifo_fwft
  import spike_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [15:0]         wr_data,
  input  logic                rd_en,
  output logic [15:0]         rd_data,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_LOG2:0] level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Head is forced to zero when empty so stale storage never shows on the port.
  assign rd_data = empty ? 16'h0000 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   level <= level + (DEPTH_LOG2+1)'(1);
        2'b01:   level <= level - (DEPTH_LOG2+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spike_event_packer.sv
// Timestamps spike pulses per source, round-robins them into an FWFT event FIFO; spike to rd_data in 2 clks.
// A full FIFO stalls grants and pending slots hold; a spike hitting a busy slot is counted in drop_cnt. Optional SPIKE_FRAME_MARKER_EN adds per-tick marker words.
module spike_event_packer
  import spike_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_SRC-1:0]  spike_in,
  input  logic                tick,
  input  logic                rd_en,
  output logic [15:0]         rd_data,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_LOG2:0] level,
  output logic [15:0]         drop_cnt,
  output logic [TS_W-1:0]     ts_now
);

  logic [NUM_SRC-1:0] pending;
  logic [TS_W-1:0]    pending_ts [NUM_SRC];
  logic [SRC_W-1:0]   rr_ptr;
  logic [TS_W-1:0]    ts_next;

  logic               grant_found;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_vld;
  logic [NUM_SRC-1:0] grant;
  logic               spike_grant_en;
  logic [2:0]         drop_inc;

  logic               marker_wr;
  logic               marker_drop;
  logic [TS_W-1:0]    marker_word_ts;

  logic               wr_en;
  event_t             wr_evt;

  assign ts_next = ts_now + TS_W'(1);

`ifdef SPIKE_FRAME_MARKER_EN
  logic            marker_pend;
  logic [TS_W-1:0] marker_ts;

  // An older held marker goes out first; a tick that finds the slot occupied while full is lost.
  always_comb begin
    marker_wr      = 1'b0;
    marker_drop    = 1'b0;
    marker_word_ts = marker_ts;
    if (!full && (marker_pend || tick)) begin
      marker_wr      = 1'b1;
      marker_word_ts = marker_pend ? marker_ts : ts_next;
    end
    if (tick && marker_pend && full) begin
      marker_drop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      marker_pend <= 1'b0;
      marker_ts   <= '0;
    end else if (tick && (full || marker_pend) && !(marker_pend && full)) begin
      marker_pend <= 1'b1;
      marker_ts   <= ts_next;
    end else if (marker_wr) begin
      marker_pend <= 1'b0;
    end
  end
`else
  assign marker_wr      = 1'b0;
  assign marker_drop    = 1'b0;
  assign marker_word_ts = '0;
`endif

  assign spike_grant_en = !full && !marker_wr;

  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end
      if (!grant_found && pending[idx]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(idx);
      end
    end
  end

  assign grant_vld = grant_found && spike_grant_en;

  always_comb begin
    grant    = '0;
    drop_inc = 3'(marker_drop);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_vld && (int'(grant_idx) == i)) begin
        grant[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      drop_inc = drop_inc + 3'(spike_in[i] && pending[i] && !grant[i]);
    end
  end

  always_comb begin
    wr_en  = marker_wr || grant_vld;
    wr_evt = '{src: grant_idx, ts: pending_ts[grant_idx]};
    if (marker_wr) begin
      wr_evt = '{src: SRC_MARKER, ts: marker_word_ts};
    end
  end

  // A slot being granted this cycle may be re-armed by a new spike without loss.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        pending_ts[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (spike_in[i] && (!pending[i] || grant[i])) begin
          pending[i]    <= 1'b1;
          pending_ts[i] <= ts_now;
        end else if (grant[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      ts_now   <= '0;
      drop_cnt <= '0;
    end else begin
      if (grant_vld) begin
        rr_ptr <= (int'(grant_idx) == NUM_SRC-1) ? '0 : grant_idx + SRC_W'(1);
      end
      if (tick) begin
        ts_now <= ts_next;
      end
      drop_cnt <= sat_add16(drop_cnt, drop_inc);
    end
  end

  spike_fifo_fwft #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_evt),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .level   (level)
  );

endmodule

// File: tb/tb_spike_event_packer.sv
// Directed bench for spike_event_packer with a 4-deep FIFO: vector table plus wrap, reset and marker sequences.
module tb_spike_event_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  spike_in;
  logic        tick;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        empty;
  logic        full;
  logic [2:0]  level;
  logic [15:0] drop_cnt;
  logic [13:0] ts_now;

  int checks = 0;
  int errors = 0;

  spike_event_packer #(
    .NUM_SRC    (3),
    .DEPTH_LOG2 (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .spike_in (spike_in),
    .tick     (tick),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .drop_cnt (drop_cnt),
    .ts_now   (ts_now)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [2:0]  sp;
    bit          tk;
    bit          rd;
    logic [15:0] data;
    bit          emp;
    bit          ful;
    logic [2:0]  lvl;
    logic [15:0] drop;
    logic [13:0] ts;
  } vec_t;

  vec_t vq[$];

  logic [50:0] obs;
  assign obs = {rd_data, empty, full, level, drop_cnt, ts_now};

  task automatic add(input bit rst, input logic [2:0] sp, input bit tk, input bit rd,
                     input logic [15:0] d, input bit e, input bit f, input logic [2:0] l,
                     input logic [15:0] dr, input logic [13:0] t);
    vec_t v;
    v.rst = rst; v.sp = sp; v.tk = tk; v.rd = rd;
    v.data = d; v.emp = e; v.ful = f; v.lvl = l; v.drop = dr; v.ts = t;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] sp, input bit tk, input bit rd);
    spike_in = sp; tick = tk; rd_en = rd;
    @(posedge clk); #1;
    spike_in = '0; tick = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; spike_in = '0; tick = 1'b0; rd_en = 1'b0;
    #3;
    chk("reset_state", 64'(obs), 64'({16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 14'd0}));
    @(posedge clk); #1;
    reset_n = 1'b1;

`ifndef SPIKE_FRAME_MARKER_EN
    // Single spike at ts=5, pop, empty read ignored, concurrent read+write keeps level.
    for (int i = 1; i <= 5; i++) add(0, 3'b000, 1, 0, 16'h0000, 1, 0, 3'd0, 16'd0, 14'(i));
    add(0, 3'b001, 0, 0, 16'h0000, 1, 0, 3'd0, 16'd0, 14'd5);
    add(0, 3'b000, 0, 0, 16'h0005, 0, 0, 3'd1, 16'd0, 14'd5);
    add(0, 3'b000, 0, 1, 16'h0000, 1, 0, 3'd0, 16'd0, 14'd5);
    add(0, 3'b000, 0, 1, 16'h0000, 1, 0, 3'd0, 16'd0, 14'd5);
    add(0, 3'b001, 0, 0, 16'h0000, 1, 0, 3'd0, 16'd0, 14'd5);
    add(0, 3'b000, 0, 0, 16'h0005, 0, 0, 3'd1, 16'd0, 14'd5);
    add(0, 3'b001, 0, 0, 16'h0005, 0, 0, 3'd1, 16'd0, 14'd5);
    add(0, 3'b000, 0, 1, 16'h0005, 0, 0, 3'd1, 16'd0, 14'd5);
    add(0, 3'b000, 0, 1, 16'h0000, 1, 0, 3'd0, 16'd0, 14'd5);
    // Reset, then three simultaneous spikes at ts=7.
    add(1, 3'b000, 0, 0, 16'h0000, 1, 0, 3'd0, 16'd0, 14'd0);
    for (int i = 1; i <= 7; i++) add(0, 3'b000, 1, 0, 16'h0000, 1, 0, 3'd0, 16'd0, 14'(i));
    add(0, 3'b111, 0, 0, 16'h0000, 1, 0, 3'd0, 16'd0, 14'd7);
    add(0, 3'b000, 0, 0, 16'h0007, 0, 0, 3'd1, 16'd0, 14'd7);
    add(0, 3'b000, 0, 0, 16'h0007, 0, 0, 3'd2, 16'd0, 14'd7);
    add(0, 3'b000, 0, 0, 16'h0007, 0, 0, 3'd3, 16'd0, 14'd7);
    add(0, 3'b000, 0, 1, 16'h4007, 0, 0, 3'd2, 16'd0, 14'd7);
    add(0, 3'b000, 0, 1, 16'h8007, 0, 0, 3'd1, 16'd0, 14'd7);
    add(0, 3'b000, 0, 1, 16'h0000, 1, 0, 3'd0, 16'd0, 14'd7);
    // Fill to 4, then collide on source 0 while full.
    add(0, 3'b001, 0, 0, 16'h0000, 1, 0, 3'd0, 16'd0, 14'd7);
    add(0, 3'b001, 0, 0, 16'h0007, 0, 0, 3'd1, 16'd0, 14'd7);
    add(0, 3'b001, 0, 0, 16'h0007, 0, 0, 3'd2, 16'd0, 14'd7);
    add(0, 3'b001, 0, 0, 16'h0007, 0, 0, 3'd3, 16'd0, 14'd7);
    add(0, 3'b000, 0, 0, 16'h0007, 0, 1, 3'd4, 16'd0, 14'd7);
    add(0, 3'b000, 1, 0, 16'h0007, 0, 1, 3'd4, 16'd0, 14'd8);
    add(0, 3'b001, 0, 0, 16'h0007, 0, 1, 3'd4, 16'd0, 14'd8);
    add(0, 3'b001, 0, 0, 16'h0007, 0, 1, 3'd4, 16'd1, 14'd8);
    add(0, 3'b000, 0, 1, 16'h0007, 0, 0, 3'd3, 16'd1, 14'd8);
    add(0, 3'b000, 0, 0, 16'h0007, 0, 1, 3'd4, 16'd1, 14'd8);
    add(0, 3'b000, 0, 1, 16'h0007, 0, 0, 3'd3, 16'd1, 14'd8);
    add(0, 3'b000, 0, 1, 16'h0007, 0, 0, 3'd2, 16'd1, 14'd8);
    add(0, 3'b000, 0, 1, 16'h0008, 0, 0, 3'd1, 16'd1, 14'd8);
    add(0, 3'b000, 0, 1, 16'h0000, 1, 0, 3'd0, 16'd1, 14'd8);

    for (int i = 0; i < vq.size(); i++) begin
      reset_n  = !vq[i].rst;
      spike_in = vq[i].sp;
      tick     = vq[i].tk;
      rd_en    = vq[i].rd;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), 64'(obs),
          64'({vq[i].data, vq[i].emp, vq[i].ful, vq[i].lvl, vq[i].drop, vq[i].ts}));
      reset_n = 1'b1;
    end
    spike_in = '0; tick = 1'b0; rd_en = 1'b0;

    // Timestamp wrap: spike on source 1 in the same cycle as the wrapping tick.
    do_reset();
    for (int i = 0; i < 16383; i++) step(3'b000, 1, 0);
    chk("wrap_ts_max", 64'(ts_now), 64'(14'h3FFF));
    step(3'b010, 1, 0);
    chk("wrap_ts_zero", 64'({ts_now, empty}), 64'({14'd0, 1'b1}));
    step(3'b000, 0, 0);
    chk("wrap_word", 64'({rd_data, level}), 64'({16'h7FFF, 3'd1}));

    // Build up a full FIFO with drops, then assert reset between clock edges.
    step(3'b111, 1, 0);
    step(3'b111, 0, 0);
    step(3'b000, 0, 0);
    step(3'b000, 0, 0);
    step(3'b000, 0, 0);
    chk("pre_reset", 64'({full, level, drop_cnt, ts_now}), 64'({1'b1, 3'd4, 16'd2, 14'd1}));
    reset_n = 1'b0;
    #2;
    chk("async_reset", 64'(obs), 64'({16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 14'd0}));
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step(3'b000, 0, 0);
    chk("no_stale", 64'({rd_data, empty, level}), 64'({16'h0000, 1'b1, 3'd0}));
`else
    // Drain each marker as it arrives until ts_now reaches 9.
    for (int i = 0; i < 9; i++) begin
      step(3'b000, 1, 0);
      step(3'b000, 0, 1);
    end
    chk("mk_idle", 64'({empty, ts_now}), 64'({1'b1, 14'd9}));
    step(3'b010, 1, 0);
    chk("mk_first", 64'({rd_data, level}), 64'({16'hC00A, 3'd1}));
    step(3'b000, 0, 0);
    chk("mk_then_spike", 64'({rd_data, level}), 64'({16'hC00A, 3'd2}));
    step(3'b000, 0, 1);
    chk("mk_spike_word", 64'({rd_data, level}), 64'({16'h4009, 3'd1}));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
